// File: rtl/alarm_pkg.sv
// Shared types and constants for the multi-channel alarm controller.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_DISARMED,
    ST_ARMED,
    ST_RINGING,
    ST_SNOOZED
  } alarm_state_e;

  typedef logic [15:0] bcd_hhmm_t;
  typedef logic [23:0] bcd_hhmmss_t;

  localparam int unsigned SEC_PER_MIN = 60;

  // A channel matches only on the whole minute, i.e. when the seconds digits read 00.
  function automatic logic time_match(input bcd_hhmmss_t now, input bcd_hhmm_t alarm);
    return (now[23:8] == alarm) && (now[7:0] == 8'h00);
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: stored hh:mm, four-state FSM, ring and snooze counters.
module alarm_channel
  import alarm_pkg::*;
#(
  parameter int RING_SEC   = 30,
  parameter int SNOOZE_MIN = 5
) (
  input  logic        clk,
  input  logic        rst_n_i,
  input  logic        sec_tick_i,
  input  bcd_hhmmss_t clock_time_i,
  input  logic        wr_en_i,
  input  bcd_hhmm_t   wr_time_i,
  input  logic        wr_arm_i,
  input  logic        ack_i,
  input  logic        snooze_i,
  output logic        ring_o,
  output logic        armed_o
);

  localparam int SNOOZE_TICKS = SNOOZE_MIN * SEC_PER_MIN;
  localparam int RW = $clog2(RING_SEC + 1);
  localparam int SW = $clog2(SNOOZE_TICKS + 1);
  localparam logic [RW-1:0] RING_LAST   = RW'(RING_SEC - 1);
  localparam logic [SW-1:0] SNOOZE_LAST = SW'(SNOOZE_TICKS - 1);

  alarm_state_e  state_q, state_d;
  bcd_hhmm_t     time_q, time_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic [SW-1:0] snz_cnt_q, snz_cnt_d;
  logic          ring_q, armed_q;

  always_comb begin
    state_d    = state_q;
    time_d     = time_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    // A write wins over every other event this cycle, so a write that lands on the
    // matching tick cannot ring until the same time comes round again.
    if (wr_en_i) begin
      time_d     = wr_time_i;
      state_d    = wr_arm_i ? ST_ARMED : ST_DISARMED;
      ring_cnt_d = '0;
      snz_cnt_d  = '0;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (sec_tick_i && time_match(clock_time_i, time_q)) begin
            state_d    = ST_RINGING;
            ring_cnt_d = '0;
          end
        end
        ST_RINGING: begin
          if (ack_i) begin
            state_d = ST_ARMED;
          end else if (snooze_i) begin
            state_d   = ST_SNOOZED;
            snz_cnt_d = '0;
          end else if (sec_tick_i) begin
            if (ring_cnt_q == RING_LAST) state_d = ST_ARMED;
            else ring_cnt_d = ring_cnt_q + RW'(1);
          end
        end
        ST_SNOOZED: begin
          if (ack_i) begin
            state_d = ST_ARMED;
          end else if (sec_tick_i) begin
            if (snz_cnt_q == SNOOZE_LAST) begin
              state_d    = ST_RINGING;
              ring_cnt_d = '0;
            end else begin
              snz_cnt_d = snz_cnt_q + SW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      state_q    <= ST_DISARMED;
      time_q     <= '0;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      ring_q     <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      time_q     <= time_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      ring_q     <= (state_d == ST_RINGING);
      armed_q    <= (state_d != ST_DISARMED);
    end
  end

  assign ring_o  = ring_q;
  assign armed_o = armed_q;

endmodule

// File: rtl/alarm_multi_ctrl.sv
// N_ALARM independent alarm channels sharing one clock time, with common ack/snooze.
module alarm_multi_ctrl
  import alarm_pkg::*;
#(
  parameter  int N_ALARM    = 4,
  parameter  int RING_SEC   = 30,
  parameter  int SNOOZE_MIN = 5,
  localparam int IDX_W      = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sec_tick,
  input  logic [23:0]        clock_time,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [15:0]        wr_time,
  input  logic               wr_arm,
  input  logic               ack,
  input  logic               snooze,
  output logic [N_ALARM-1:0] ring_vec,
  output logic               alarm_en,
  output logic [N_ALARM-1:0] armed_vec
);

  logic [N_ALARM-1:0] wr_sel;

  for (genvar i = 0; i < N_ALARM; i++) begin : g_ch
    assign wr_sel[i] = wr_en && (wr_idx == IDX_W'(i));

    alarm_channel #(
      .RING_SEC  (RING_SEC),
      .SNOOZE_MIN(SNOOZE_MIN)
    ) u_ch (
      .clk         (clk),
      .rst_n_i     (rst_n),
      .sec_tick_i  (sec_tick),
      .clock_time_i(clock_time),
      .wr_en_i     (wr_sel[i]),
      .wr_time_i   (wr_time),
      .wr_arm_i    (wr_arm),
      .ack_i       (ack),
      .snooze_i    (snooze),
      .ring_o      (ring_vec[i]),
      .armed_o     (armed_vec[i])
    );
  end

  // Built from registered ring flags, so it changes on the same edge as ring_vec.
  assign alarm_en = |ring_vec;

endmodule
